// File: rtl/mole_game_pkg.sv
// Shared constants for the whack-a-mole game controller: FSM encoding and LFSR shape.
package mole_game_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    OVER = 2'd3
  } state_t;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used as the mole-selection entropy source.
module mole_lfsr
  import mole_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] out
);

  // Right-shifting Galois form; a non-zero seed keeps the state non-zero forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= SEED;
    end else begin
      out <= {1'b0, out[LFSR_W-1:1]} ^ (out[0] ? LFSR_TAPS : LFSR_W'(0));
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: raises random moles, judges whacks, tracks score/misses/time.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int unsigned       NUM_MOLES  = 4,
  parameter int unsigned       GAME_TICKS = 600,
  parameter int unsigned       MOLE_TICKS = 20,
  parameter int unsigned       GAP_TICKS  = 5,
  parameter int unsigned       SCORE_W    = 8,
  parameter int unsigned       TIME_W     = 10,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start_btn,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [1:0]           state,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [TIME_W-1:0]    time_left,
  output logic                 game_over
);

  localparam int unsigned MOLE_W  = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
  localparam int unsigned CNT_MAX = (GAP_TICKS > MOLE_TICKS) ? GAP_TICKS : MOLE_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [MOLE_W:0] NUM_W = (MOLE_W + 1)'(NUM_MOLES);

  state_t               state_q, state_n;
  logic                 start_q, start_e;
  logic [NUM_MOLES-1:0] hit_q, hit_e;
  logic [LFSR_W-1:0]    lfsr;
  logic                 lfsr_unused;
  logic [MOLE_W-1:0]    mole_q, mole_n, pick;
  logic [MOLE_W:0]      raw, sel, inc;
  logic [CNT_W-1:0]     gap_q, gap_n, mcnt_q, mcnt_n;
  logic [NUM_MOLES-1:0] onehot_n;
  logic [SCORE_W-1:0]   score_n, misses_n;
  logic [TIME_W-1:0]    time_n;
  logic                 over_n, time_end, hit_good, hit_bad;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W:0] s;
    s = {1'b0, v} + (SCORE_W + 1)'(1);
    return s[SCORE_W] ? v : s[SCORE_W-1:0];
  endfunction

  mole_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign lfsr_unused = ^lfsr[LFSR_W-1:MOLE_W];
  assign start_e     = start_btn & ~start_q;
  assign hit_e       = hit & ~hit_q;
  assign state       = state_q;

  // Fold the raw LFSR bits into range, then step past the previous mole.
  always_comb begin
    raw  = {1'b0, lfsr[MOLE_W-1:0]};
    sel  = (raw >= NUM_W) ? raw - NUM_W : raw;
    inc  = sel + (MOLE_W + 1)'(1);
    if (inc == NUM_W) inc = '0;
    pick = (sel[MOLE_W-1:0] == mole_q) ? inc[MOLE_W-1:0] : sel[MOLE_W-1:0];
  end

  always_comb begin
    state_n  = state_q;
    mole_n   = mole_q;
    gap_n    = gap_q;
    mcnt_n   = mcnt_q;
    onehot_n = mole_onehot;
    score_n  = score;
    misses_n = misses;
    time_n   = time_left;
    time_end = tick && (time_left == TIME_W'(1));
    hit_good = |(hit_e & mole_onehot);
    hit_bad  = |(hit_e & ~mole_onehot);

    case (state_q)
      IDLE: begin
        if (start_e) begin
          score_n  = '0;
          misses_n = '0;
          time_n   = TIME_W'(GAME_TICKS);
          gap_n    = CNT_W'(GAP_TICKS);
          state_n  = GAP;
        end
      end
      GAP: begin
        if (time_end) begin
          time_n  = '0;
          state_n = OVER;
        end else if (tick) begin
          time_n = time_left - TIME_W'(1);
          if (gap_q == CNT_W'(1)) begin
            mole_n   = pick;
            onehot_n = NUM_MOLES'(1) << pick;
            mcnt_n   = CNT_W'(MOLE_TICKS);
            state_n  = UP;
          end else begin
            gap_n = gap_q - CNT_W'(1);
          end
        end
      end
      UP: begin
        // Round expiry swallows any hit or timeout landing in the same cycle.
        if (time_end) begin
          time_n   = '0;
          onehot_n = '0;
          state_n  = OVER;
        end else begin
          if (tick) time_n = time_left - TIME_W'(1);
          if (hit_good) begin
            score_n  = sat_inc(score);
            gap_n    = CNT_W'(GAP_TICKS);
            onehot_n = '0;
            state_n  = GAP;
          end else if (tick && (mcnt_q == CNT_W'(1))) begin
            misses_n = sat_inc(misses);
            gap_n    = CNT_W'(GAP_TICKS);
            onehot_n = '0;
            state_n  = GAP;
          end else begin
            if (hit_bad) misses_n = sat_inc(misses);
            if (tick) mcnt_n = mcnt_q - CNT_W'(1);
          end
        end
      end
      OVER: begin
        if (start_e) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    over_n = (state_n == OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      hit_q       <= '0;
      mole_q      <= '0;
      gap_q       <= '0;
      mcnt_q      <= '0;
      mole_onehot <= '0;
      score       <= '0;
      misses      <= '0;
      time_left   <= '0;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_n;
      start_q     <= start_btn;
      hit_q       <= hit;
      mole_q      <= mole_n;
      gap_q       <= gap_n;
      mcnt_q      <= mcnt_n;
      mole_onehot <= onehot_n;
      score       <= score_n;
      misses      <= misses_n;
      time_left   <= time_n;
      game_over   <= over_n;
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: a short scripted round plus a long saturating run.
module tb_mole_game_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tick = 1'b1;
  always #10 clk = ~clk;

  logic       start_btn;
  logic [4:0] hit;
  logic [1:0] state;
  logic [4:0] mole;
  logic [7:0] score, misses;
  logic [9:0] time_left;
  logic       game_over;

  logic       start_l;
  logic [4:0] hit_l;
  logic [1:0] state_l;
  logic [4:0] mole_l;
  logic [3:0] score_l, misses_l;
  logic [9:0] time_l;
  logic       over_l;

  int errors = 0;
  int checks = 0;

  mole_game_ctrl #(
    .NUM_MOLES(5), .GAME_TICKS(20), .MOLE_TICKS(3), .GAP_TICKS(2),
    .SCORE_W(8), .TIME_W(10), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(rst), .tick(tick), .start_btn(start_btn), .hit(hit),
    .state(state), .mole_onehot(mole), .score(score), .misses(misses),
    .time_left(time_left), .game_over(game_over)
  );

  mole_game_ctrl #(
    .NUM_MOLES(5), .GAME_TICKS(1023), .MOLE_TICKS(3), .GAP_TICKS(2),
    .SCORE_W(4), .TIME_W(10), .SEED(16'hACE1)
  ) dut_l (
    .clk(clk), .reset(rst), .tick(tick), .start_btn(start_l), .hit(hit_l),
    .state(state_l), .mole_onehot(mole_l), .score(score_l), .misses(misses_l),
    .time_left(time_l), .game_over(over_l)
  );

  // Reference LFSR; m_before holds the value the DUT saw at the most recent edge.
  logic [15:0] m, m_before;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m        <= 16'hACE1;
      m_before <= 16'hACE1;
    end else begin
      m_before <= m;
      m        <= m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
    end
  end

  int prev_m;

  function automatic int pick_mole(input logic [15:0] l, input int prev);
    int r;
    r = int'(l[2:0]);
    if (r >= 5) r -= 5;
    if (r == prev) r = (r + 1) % 5;
    return r;
  endfunction

  function automatic int idx_of(input logic [4:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 5; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_up(input string tag, output int k);
    logic [4:0] oh;
    k  = pick_mole(m_before, prev_m);
    oh = 5'(1) << k;
    chk({tag, "_state"}, 32'(state), 32'd2);
    chk({tag, "_mole"}, 32'(mole), 32'(oh));
    prev_m = k;
  endtask

  int  k, j, idx, prev_l, up_age;
  bit  done, was_up;

  initial begin
    rst = 1'b1; start_btn = 1'b0; hit = '0; start_l = 1'b0; hit_l = '0; prev_m = 0;
    cyc(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_mole", 32'(mole), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_misses", 32'(misses), 0);
    chk("rst_time", 32'(time_left), 0);
    chk("rst_over", 32'(game_over), 0);
    rst = 1'b0;
    cyc(1);

    start_btn = 1'b1;
    cyc(1);
    chk("start_state", 32'(state), 1);
    chk("start_time", 32'(time_left), 20);
    chk("start_score", 32'(score), 0);
    start_btn = 1'b0;
    cyc(2);
    chk_up("up1", k);
    chk("up1_time", 32'(time_left), 18);

    hit = 5'(1) << k;
    cyc(1);
    chk("good_score", 32'(score), 1);
    chk("good_mole", 32'(mole), 0);
    chk("good_state", 32'(state), 1);
    hit = '0;

    cyc(2);
    chk_up("up2", k);
    cyc(2);
    chk("tmo_still_up", 32'(state), 2);
    cyc(1);
    chk("tmo_misses", 32'(misses), 1);
    chk("tmo_state", 32'(state), 1);
    chk("tmo_mole", 32'(mole), 0);

    cyc(2);
    chk_up("up3", k);
    chk("up3_time", 32'(time_left), 10);
    j = (k + 1) % 5;
    hit = 5'(1) << j;
    cyc(1);
    chk("wrong_misses", 32'(misses), 2);
    chk("wrong_state", 32'(state), 2);
    cyc(1);
    chk("held_misses", 32'(misses), 2);
    chk("held_state", 32'(state), 2);
    hit = '0;
    cyc(1);
    chk("tmo2_misses", 32'(misses), 3);
    chk("tmo2_state", 32'(state), 1);
    chk("tmo2_time", 32'(time_left), 7);

    cyc(2);
    chk_up("up4", k);
    hit = (5'(1) << k) | (5'(1) << ((k + 1) % 5));
    cyc(1);
    chk("both_score", 32'(score), 2);
    chk("both_misses", 32'(misses), 3);
    chk("both_state", 32'(state), 1);
    hit = '0;

    cyc(2);
    chk_up("up5", k);
    chk("up5_time", 32'(time_left), 2);
    cyc(1);
    chk("last_time", 32'(time_left), 1);
    chk("last_state", 32'(state), 2);
    hit = 5'(1) << k;
    cyc(1);
    chk("end_state", 32'(state), 3);
    chk("end_over", 32'(game_over), 1);
    chk("end_score", 32'(score), 2);
    chk("end_time", 32'(time_left), 0);
    chk("end_mole", 32'(mole), 0);
    hit = '0;
    cyc(1);
    chk("over_hold_state", 32'(state), 3);
    chk("over_hold_misses", 32'(misses), 3);

    start_btn = 1'b1;
    cyc(1);
    chk("restart_state", 32'(state), 0);
    chk("restart_over", 32'(game_over), 0);
    start_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1;
    cyc(1);
    chk("rerun_state", 32'(state), 1);
    chk("rerun_score", 32'(score), 0);
    chk("rerun_misses", 32'(misses), 0);
    chk("rerun_time", 32'(time_left), 20);
    start_btn = 1'b0;
    cyc(2);
    chk_up("up6", k);

    rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_mole", 32'(mole), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_misses", 32'(misses), 0);
    chk("mid_rst_time", 32'(time_left), 0);
    chk("mid_rst_over", 32'(game_over), 0);
    prev_m = 0;
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Long round: whack each mole one tick after it rises until the round ends.
    start_l = 1'b1;
    cyc(1);
    start_l = 1'b0;
    prev_l = 0; up_age = 0; done = 1'b0; was_up = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      if (over_l) begin
        done = 1'b1;
      end else if (state_l == 2'd2) begin
        if (!was_up) begin
          idx = idx_of(mole_l);
          chk("long_onehot", 32'($onehot(mole_l)), 1);
          chk("long_repeat", 32'(idx != prev_l), 1);
          prev_l = idx;
          up_age = 0;
          hit_l  = '0;
        end else begin
          up_age++;
          hit_l = (up_age == 1) ? mole_l : 5'd0;
        end
      end else begin
        hit_l = '0;
      end
      was_up = (state_l == 2'd2);
      if (!done) cyc(1);
    end
    hit_l = '0;
    chk("long_done", 32'(done), 1);
    chk("long_state", 32'(state_l), 3);
    chk("long_score_sat", 32'(score_l), 15);
    chk("long_misses", 32'(misses_l), 0);
    chk("long_time", 32'(time_l), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
